// File: rtl/mmu_pkg.sv
// Shared types for the timed MMU: data-port FSM states and address regions.
package mmu_pkg;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   typedef enum logic [1:0] {
      REG_INVALID,
      REG_SPECIAL,
      REG_MAIN
   } region_t;

endpackage

// File: rtl/mmu_decode.sv
// Address decoder: maps a full-width word address to a region and a word
// index inside that region. All compares are done on the full address
// (zero-extended by one bit), so high address bits can never alias into a
// valid region.
module mmu_decode
   import mmu_pkg::*;
#(
   parameter int ADDR_W        = 32,
   parameter int MEM_WORDS     = 128,
   parameter int MEM_BASE      = 16,
   parameter int SPECIAL_WORDS = 15,
   parameter int IDX_W         = 7
) (
   input  logic [ADDR_W-1:0] addr,
   output region_t           region,
   output logic [IDX_W-1:0]  idx
);

   localparam logic [ADDR_W:0] SPEC_LAST  = (ADDR_W+1)'(SPECIAL_WORDS);
   localparam logic [ADDR_W:0] MAIN_FIRST = (ADDR_W+1)'(MEM_BASE);
   localparam logic [ADDR_W:0] MAIN_END   = (ADDR_W+1)'(MEM_BASE + MEM_WORDS);

   logic [ADDR_W:0] a_ext;

   assign a_ext = {1'b0, addr};

   // Region select: 0 is invalid, then the special block, then main memory.
   always_comb begin
      region = REG_INVALID;
      idx    = '0;
      if ((a_ext != '0) && (a_ext <= SPEC_LAST)) begin
         region = REG_SPECIAL;
         idx    = IDX_W'(addr - ADDR_W'(1));
      end else if ((a_ext >= MAIN_FIRST) && (a_ext < MAIN_END)) begin
         region = REG_MAIN;
         idx    = IDX_W'(addr - ADDR_W'(MEM_BASE));
      end
   end

endmodule

// File: rtl/mmu_timed.sv
// Two-port MMU over one word store: a single-cycle fetch port and a data port
// with DATA_LAT wait cycles, byte-enable writes and a special-register block.
// Data handshake: a request (rd and/or wd) is sampled only while wait_data is
// low; wait_data stays high while the access is in flight and rd/wd are
// ignored then; completion is a one-cycle data_valid pulse, an invalid
// address gives a one-cycle data_segv pulse instead, never both.
module mmu_timed
   import mmu_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 32,
   parameter int MEM_WORDS     = 128,
   parameter int MEM_BASE      = 16,
   parameter int SPECIAL_WORDS = 15,
   parameter int DATA_LAT      = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   instr_addr,
   output logic [DATA_W-1:0]   instr,
   output logic                instr_segv,
   output logic                wait_instr,
   input  logic                rd,
   input  logic                wd,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic [DATA_W-1:0]   data,
   output logic                data_valid,
   output logic                wait_data,
   output logic                data_segv
);

   localparam int NBYTES  = DATA_W / 8;
   localparam int MIDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int SIDX_W  = (SPECIAL_WORDS > 1) ? $clog2(SPECIAL_WORDS) : 1;
   localparam int IDX_W   = (MIDX_W > SIDX_W) ? MIDX_W : SIDX_W;
   localparam logic [3:0] LAT_CNT = 4'(DATA_LAT);

   logic [DATA_W-1:0] mem     [MEM_WORDS];
   logic [DATA_W-1:0] special [SPECIAL_WORDS];

   region_t           i_region, d_region, lat_region, a_region;
   logic [IDX_W-1:0]  i_idx, d_idx, lat_idx, a_idx;
   logic [DATA_W-1:0] lat_din, a_din, cur_word, merged;
   logic [NBYTES-1:0] lat_be, a_be;
   logic              lat_rd, lat_wd, a_rd, a_wd, access_now;
   state_t            state;
   logic [3:0]        counter;

   assign wait_instr = 1'b0;

   mmu_decode #(
      .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .MEM_BASE(MEM_BASE),
      .SPECIAL_WORDS(SPECIAL_WORDS), .IDX_W(IDX_W)
   ) u_dec_instr (
      .addr(instr_addr), .region(i_region), .idx(i_idx)
   );

   mmu_decode #(
      .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS), .MEM_BASE(MEM_BASE),
      .SPECIAL_WORDS(SPECIAL_WORDS), .IDX_W(IDX_W)
   ) u_dec_data (
      .addr(data_addr), .region(d_region), .idx(d_idx)
   );

   // Pick the access operands: live inputs when idle, latched copy when busy;
   // then build the byte-merged word and decide whether the access fires now.
   always_comb begin
      a_region = d_region;
      a_idx    = d_idx;
      a_din    = data_in;
      a_be     = byte_en;
      a_rd     = rd;
      a_wd     = wd;
      if (state == BUSY) begin
         a_region = lat_region;
         a_idx    = lat_idx;
         a_din    = lat_din;
         a_be     = lat_be;
         a_rd     = lat_rd;
         a_wd     = lat_wd;
      end
      cur_word = (a_region == REG_SPECIAL) ? special[a_idx[SIDX_W-1:0]]
                                           : mem[a_idx[MIDX_W-1:0]];
      merged = cur_word;
      for (int b = 0; b < NBYTES; b++) begin
         if (a_be[b]) merged[b*8 +: 8] = a_din[b*8 +: 8];
      end
      access_now = ((state == IDLE) && (rd || wd) && (d_region != REG_INVALID) && (DATA_LAT == 0))
                || ((state == BUSY) && (counter == 4'd1));
   end

   // Fetch port, data-port FSM and the store itself; reset clears everything.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         counter    <= '0;
         instr      <= '0;
         instr_segv <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         wait_data  <= 1'b0;
         data_segv  <= 1'b0;
         lat_region <= REG_INVALID;
         lat_idx    <= '0;
         lat_din    <= '0;
         lat_be     <= '0;
         lat_rd     <= 1'b0;
         lat_wd     <= 1'b0;
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
         for (int i = 0; i < SPECIAL_WORDS; i++) special[i] <= '0;
      end else begin
         data_valid <= 1'b0;
         data_segv  <= 1'b0;

         if (i_region == REG_MAIN) begin
            instr      <= mem[i_idx[MIDX_W-1:0]];
            instr_segv <= 1'b0;
         end else begin
            instr_segv <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (rd || wd) begin
                  if (d_region == REG_INVALID) begin
                     data_segv <= 1'b1;
                  end else if (DATA_LAT != 0) begin
                     lat_region <= d_region;
                     lat_idx    <= d_idx;
                     lat_din    <= data_in;
                     lat_be     <= byte_en;
                     lat_rd     <= rd;
                     lat_wd     <= wd;
                     counter    <= LAT_CNT;
                     wait_data  <= 1'b1;
                     state      <= BUSY;
                  end
               end
            end
            BUSY: begin
               counter <= counter - 4'd1;
               if (counter == 4'd1) begin
                  wait_data <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (access_now) begin
            if (a_wd) begin
               if (a_region == REG_SPECIAL) special[a_idx[SIDX_W-1:0]] <= merged;
               else mem[a_idx[MIDX_W-1:0]] <= merged;
            end
            if (a_rd) data <= a_wd ? merged : cur_word;
            data_valid <= 1'b1;
         end
      end
   end

endmodule
